// File: rtl/sram8x32_dff.sv
// sram8x32_dff: 8 x 32-bit flip-flop memory with a registered read address.
// A cycle with we = 1 writes wd into the word at add. A cycle with we = 0 loads add into
// the read-address register. rd is a purely combinational view of the word that the
// read-address register selects. Reset clears every word and the read address at once.
module sram8x32_dff (
   input  logic        clk,
   input  logic        resetn,
   input  logic [2:0]  add,
   input  logic        we,
   input  logic [31:0] wd,
   output logic [31:0] rd
);

   localparam int unsigned Words = 8;

   logic [31:0] r_mem [Words];
   logic [2:0]  r_add_rd;
   logic [7:0]  w_wen;
   logic [31:0] w_rd;

   // One-hot address decode: exactly one bit is set for every value of add.
   always_comb begin
      w_wen = 8'h00;
      unique case (add)
         3'd0: w_wen = 8'b0000_0001;
         3'd1: w_wen = 8'b0000_0010;
         3'd2: w_wen = 8'b0000_0100;
         3'd3: w_wen = 8'b0000_1000;
         3'd4: w_wen = 8'b0001_0000;
         3'd5: w_wen = 8'b0010_0000;
         3'd6: w_wen = 8'b0100_0000;
         3'd7: w_wen = 8'b1000_0000;
         default: w_wen = 8'h00;
      endcase
   end

   // Storage words: only the decoded word takes wd, and only on a write cycle.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < Words; i++) begin
            r_mem[i] <= 32'h0000_0000;
         end
      end else if (we) begin
         for (int i = 0; i < Words; i++) begin
            if (w_wen[i]) begin
               r_mem[i] <= wd;
            end
         end
      end
   end

   // Read address: loads on read-address cycles and holds across write cycles.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_add_rd <= 3'b000;
      end else if (!we) begin
         r_add_rd <= add;
      end
   end

   // Unregistered 8:1 read mux. A write to the selected word shows up right after its edge.
   always_comb begin
      w_rd = 32'h0000_0000;
      unique case (r_add_rd)
         3'd0: w_rd = r_mem[0];
         3'd1: w_rd = r_mem[1];
         3'd2: w_rd = r_mem[2];
         3'd3: w_rd = r_mem[3];
         3'd4: w_rd = r_mem[4];
         3'd5: w_rd = r_mem[5];
         3'd6: w_rd = r_mem[6];
         3'd7: w_rd = r_mem[7];
         default: w_rd = 32'h0000_0000;
      endcase
   end

   assign rd = w_rd;

endmodule

// File: tb/tb_sram8x32_dff.sv
// Directed bench for sram8x32_dff. Expected values are written out by hand, with a small
// array tracking what each word should hold.
module tb_sram8x32_dff;

   logic        clk;
   logic        resetn;
   logic [2:0]  add;
   logic        we;
   logic [31:0] wd;
   logic [31:0] rd;

   int          n_assert;
   int          n_fail;
   logic [31:0] exp_mem [8];

   sram8x32_dff dut (
      .clk    (clk),
      .resetn (resetn),
      .add    (add),
      .we     (we),
      .wd     (wd),
      .rd     (rd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Wait for a rising edge, then move 1 ns past it so that outputs have settled.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      we  = 1'b1;
      add = a;
      wd  = d;
      step();
   endtask

   task automatic rd_load(input logic [2:0] a);
      we  = 1'b0;
      add = a;
      wd  = $urandom;
      step();
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      resetn   = 1'b0;
      we       = 1'b1;
      add      = 3'd0;
      wd       = 32'h0;
      for (int i = 0; i < 8; i++) exp_mem[i] = 32'h0;

      // While reset is held, writes with random data and addresses must be ignored.
      #1;
      check("reset_rd_initial", rd, 32'h0);
      for (int i = 0; i < 4; i++) begin
         we  = 1'b1;
         add = 3'($urandom_range(0, 7));
         wd  = $urandom;
         step();
         check("reset_rd_during_writes", rd, 32'h0);
         we = 1'b0;
         step();
         check("reset_rd_during_loads", rd, 32'h0);
      end
      resetn = 1'b1;

      // After release, every word reads back zero.
      for (int i = 0; i < 8; i++) begin
         rd_load(3'(i));
         check($sformatf("post_reset_word%0d", i), rd, 32'h0);
      end

      // Fill, then read back with a latency of one edge.
      for (int i = 0; i < 8; i++) begin
         wr(3'(i), 32'hA5A5_0000 + 32'(i));
         exp_mem[i] = 32'hA5A5_0000 + 32'(i);
      end
      for (int i = 0; i < 8; i++) begin
         rd_load(3'(i));
         check($sformatf("fill_read_word%0d", i), rd, 32'hA5A5_0000 + 32'(i));
      end

      // Read hold: writes to word 5 must leave rd showing word 3.
      rd_load(3'd3);
      check("hold_initial_word3", rd, 32'hA5A5_0003);
      wr(3'd5, 32'h1234_5678);
      exp_mem[5] = 32'h1234_5678;
      check("hold_after_write1", rd, 32'hA5A5_0003);
      wr(3'd5, 32'h8765_4321);
      exp_mem[5] = 32'h8765_4321;
      check("hold_after_write2", rd, 32'hA5A5_0003);
      rd_load(3'd5);
      check("hold_word5_readback", rd, 32'h8765_4321);

      // Write-through to the currently selected word.
      rd_load(3'd2);
      check("wt_before", rd, 32'hA5A5_0002);
      wr(3'd2, 32'hDEAD_BEEF);
      exp_mem[2] = 32'hDEAD_BEEF;
      check("wt_after", rd, 32'hDEAD_BEEF);

      // Isolation: writing word 7 leaves the other words untouched.
      wr(3'd7, 32'hFFFF_FFFF);
      exp_mem[7] = 32'hFFFF_FFFF;
      for (int i = 0; i < 8; i++) begin
         rd_load(3'(i));
         check($sformatf("iso_word%0d", i), rd, exp_mem[i]);
      end

      // Mid-run reset between edges clears rd at once; the edges seen during reset are ignored.
      rd_load(3'd7);
      check("midrst_before", rd, 32'hFFFF_FFFF);
      #2;
      resetn = 1'b0;
      #1;
      check("midrst_immediate", rd, 32'h0);
      wr(3'd4, 32'hCAFE_F00D);
      check("midrst_write_ignored_rd", rd, 32'h0);
      rd_load(3'd6);
      check("midrst_load_ignored_rd", rd, 32'h0);
      resetn = 1'b1;
      for (int i = 0; i < 8; i++) begin
         rd_load(3'(i));
         check($sformatf("midrst_word%0d", i), rd, 32'h0);
      end

      // The first edge after release works normally.
      wr(3'd1, 32'h0BAD_CAFE);
      check("post_rst_write_sel0", rd, 32'h0);
      rd_load(3'd1);
      check("post_rst_read1", rd, 32'h0BAD_CAFE);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   // Guard against an unexpected stall.
   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/sram8x32_dff.md
SRAM8X32_DFF -- requirements
Module: sram8x32_dff

Interface
REQ-001 Parameters: none; geometry fixed at 8 words x 32 bits, 3-bit address.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 resetn  input  1  reset; asynchronous, active-low.
REQ-004 add  input  3  word address; selects write target and candidate read address.
REQ-005 we  input  1  write enable; 1 = write cycle, 0 = read-address-load cycle.
REQ-006 wd  input  32  write data.
REQ-007 rd  output  32  read data.

Function
REQ-008 Storage SHALL be 8 x 32-bit flip-flop registers, REG[0..7].
REQ-009 Address decoder SHALL be combinational one-hot: wen[i] = 1 iff add == i, exactly one bit set for every add value.
REQ-010 On a rising clk edge with we = 1, REG[add] SHALL take wd; the other 7 words SHALL hold.
REQ-011 On a rising clk edge with we = 0, no REG word SHALL change.
REQ-012 A 3-bit read-address register add_rd SHALL load add on a rising edge when we = 0 and SHALL hold when we = 1.
REQ-013 rd SHALL be a combinational 8:1 mux of REG indexed by add_rd, with no further registering.
REQ-014 Read latency: an address presented with we = 0 SHALL appear as REG[add] on rd immediately after the next rising edge.
REQ-015 During write cycles (we = 1), rd SHALL keep showing the word at the held add_rd, not the word at add.
REQ-016 Write to the word currently selected by add_rd: rd SHALL show the new wd immediately after the writing edge.
REQ-017 All 8 add values SHALL be valid for write and read; there is no out-of-range address.
REQ-018 Write and read-address load are mutually exclusive per edge; both SHALL be fully determined by we.

Reset
REQ-019 While resetn = 0, all REG words SHALL be 32'h0000_0000 and add_rd SHALL be 3'b000, asynchronously to clk.
REQ-020 While resetn = 0, rd SHALL read 32'h0000_0000.
REQ-021 Clock edges while resetn = 0 SHALL be ignored; writes and address loads SHALL be lost.
REQ-022 After resetn rises, the first rising edge SHALL operate normally per REQ-010 to REQ-012.
REQ-023 Reset asserted mid-sequence SHALL clear all stored data and add_rd at once, with no completion of a pending write.

Verification
REQ-024 Reset: resetn = 0 with random wd, add and we = 1 toggling -> rd = 0; after release, read each address with we = 0 -> rd = 0 for all 8 words.
REQ-025 Fill and readback: write wd = 32'hA5A5_0000 + i to add = i for i = 0..7, then read each with we = 0 -> rd = 32'hA5A5_0000 + i one edge after each address.
REQ-026 Read hold: read add = 3 (rd = data3), then we = 1 with writes to add = 5 -> rd stays data3 throughout.
REQ-027 Write-through: add_rd = 2, write 32'hDEAD_BEEF to add = 2 -> rd = 32'hDEAD_BEEF immediately after that edge.
REQ-028 Isolation: write 32'hFFFF_FFFF to add = 7 only -> words 0..6 read back unchanged.
REQ-029 Mid-run reset: after fill, pulse resetn low between edges -> rd = 0 at once, and all words read 0 afterwards.
